// File: rtl/mem_checker_pkg.sv
// Shared types and default bus widths for the memory checker and its responder.
package mem_checker_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 11;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        WR_BURST_S = 2'd1,
        RD_BURST_S = 2'd2
    } resp_state_t;

endpackage

// File: rtl/amm_resp_ram.sv
// Single-port, write-first, byte-enabled synchronous RAM (DATA_W x 2^DEPTH_W).
module amm_resp_ram #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH_W = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_W-1:0]    addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** DEPTH_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] merged_c;

    // Word as it will look after this cycle's write; also the write-first read value.
    always_comb begin
        merged_c = mem_q[addr_i];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (be_i[b]) begin
                merged_c[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_o <= we_i ? merged_c : mem_q[addr_i];
    end

endmodule

// File: rtl/amm_mem_responder.sv
// Avalon-MM burst memory responder: one burst at a time, fixed RD_LATENCY read pipe.
// Optional read-data error injection when AMM_RESP_ERR_INJ_EN is defined.
module amm_mem_responder #(
    parameter int unsigned ADDR_W      = mem_checker_pkg::ADDR_W,
    parameter int unsigned DATA_W      = mem_checker_pkg::DATA_W,
    parameter int unsigned BURST_W     = mem_checker_pkg::BURST_W,
    parameter int unsigned MEM_DEPTH_W = 10,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADDR_W-1:0]      address_slave,
    input  logic                   write_slave,
    input  logic [DATA_W-1:0]      writedata_slave,
    input  logic [DATA_W/8-1:0]    byteenable_slave,
    input  logic                   read_slave,
    input  logic [BURST_W-1:0]     burstcount_slave,
`ifdef AMM_RESP_ERR_INJ_EN
    input  logic                   err_inj_en_i,
    input  logic [MEM_DEPTH_W-1:0] err_addr_i,
    input  logic [DATA_W-1:0]      err_mask_i,
`endif
    output logic                   waitrequest_slave,
    output logic [DATA_W-1:0]      readdata_slave,
    output logic                   readdatavalid_slave
);

    import mem_checker_pkg::*;

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned AW   = MEM_DEPTH_W;

    resp_state_t          state_q, state_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic [BURST_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [BURST_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                 wait_q, wait_d;
    logic                 collision_q, collision_d;

    logic                 ram_we_c;
    logic [AW-1:0]        ram_addr_c;
    logic [DATA_W-1:0]    ram_rdata;
    logic                 issue_c;
    logic [DATA_W-1:0]    issue_mask_c;
    logic [BURST_W-1:0]   bc_eff_c;
    logic                 unused_addr_bits;

    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]     mask_q;
    logic [DATA_W-1:0]     s1_data_c;

    // Upper address bits alias onto the RAM.
    assign unused_addr_bits = ^address_slave;
    assign bc_eff_c = (burstcount_slave == '0) ? BURST_W'(1) : burstcount_slave;

    // Next-state, counter and RAM-port control.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        collision_d = collision_q;
        ram_we_c    = 1'b0;
        ram_addr_c  = rd_addr_q;
        issue_c     = 1'b0;

        case (state_q)
            IDLE_S: begin
                if (!wait_q && write_slave) begin
                    ram_we_c    = 1'b1;
                    ram_addr_c  = address_slave[AW-1:0];
                    wr_addr_d   = address_slave[AW-1:0] + AW'(1);
                    wr_cnt_d    = bc_eff_c - BURST_W'(1);
                    collision_d = collision_q | read_slave;
                    if (bc_eff_c != BURST_W'(1)) begin
                        state_d = WR_BURST_S;
                    end
                end else if (!wait_q && read_slave) begin
                    rd_addr_d = address_slave[AW-1:0];
                    rd_cnt_d  = bc_eff_c;
                    state_d   = RD_BURST_S;
                end
            end
            WR_BURST_S: begin
                ram_addr_c = wr_addr_q;
                if (write_slave) begin
                    ram_we_c  = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    wr_cnt_d  = wr_cnt_q - BURST_W'(1);
                    if (wr_cnt_q == BURST_W'(1)) begin
                        state_d = IDLE_S;
                    end
                end
            end
            RD_BURST_S: begin
                issue_c   = 1'b1;
                rd_addr_d = rd_addr_q + AW'(1);
                rd_cnt_d  = rd_cnt_q - BURST_W'(1);
                if (rd_cnt_q == BURST_W'(1)) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase

        wait_d = (state_d == RD_BURST_S);
    end

`ifdef AMM_RESP_ERR_INJ_EN
    // Corruption decided at issue so it travels with that beat's valid.
    assign issue_mask_c = (issue_c && err_inj_en_i && (rd_addr_q == err_addr_i)) ? err_mask_i : '0;
`else
    assign issue_mask_c = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE_S;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wait_q      <= 1'b1;
            collision_q <= 1'b0;
            mask_q      <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_q      <= wait_d;
            collision_q <= collision_d;
            mask_q      <= issue_mask_c;
            vld_q[0]    <= issue_c;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    amm_resp_ram #(
        .DATA_W  (DATA_W),
        .DEPTH_W (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .be_i    (byteenable_slave[BE_W-1:0]),
        .wdata_i (writedata_slave),
        .rdata_o (ram_rdata)
    );

    // RAM output register is stage 1 of the read pipe.
    assign s1_data_c = ram_rdata ^ mask_q;

    if (RD_LATENCY > 1) begin : g_dpipe
        logic [DATA_W-1:0] dat_q [RD_LATENCY-1];

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                dat_q[0] <= s1_data_c;
                for (int i = 1; i < int'(RD_LATENCY) - 1; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign readdata_slave = dat_q[RD_LATENCY-2];
    end else begin : g_dnopipe
        assign readdata_slave = vld_q[0] ? s1_data_c : '0;
    end

    assign waitrequest_slave   = wait_q;
    assign readdatavalid_slave = vld_q[RD_LATENCY-1];

endmodule

// File: doc/amm_mem_responder.md
Name: amm_mem_responder

Overview:
- Avalon-MM burst-capable memory responder: the slave end of the memory checker's master interface.
- Stores write bursts into an internal word RAM and returns read bursts with fixed, parameterised read latency.
- Serves as the memory under test in simulation and as an on-chip target in loopback builds.
- Handles one burst at a time; waitrequest throttles the initiator.

Parameters:
- ADDR_W, 16, word address width on the bus.
- DATA_W, 32, data width; must be a multiple of 8.
- BURST_W, 11, burstcount width.
- MEM_DEPTH_W, 10, log2 of RAM depth in words; only address bits [MEM_DEPTH_W-1:0] are used.
- RD_LATENCY, 2, cycles from internal read issue to readdatavalid; legal range 1..8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- address_slave  in  ADDR_W  burst start word address.
- write_slave  in  1  write beat request.
- writedata_slave  in  DATA_W  write data.
- byteenable_slave  in  DATA_W/8  per-byte write enable.
- read_slave  in  1  read burst request.
- burstcount_slave  in  BURST_W  beats in burst; 0 is treated as 1.
- waitrequest_slave  out  1  command or beat not accepted this cycle.
- readdata_slave  out  DATA_W  read data.
- readdatavalid_slave  out  1  readdata_slave valid.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE_S; read pipe flushed.
  - readdatavalid_slave = 0, readdata_slave = 0, waitrequest_slave = 1.
  - RAM contents are not cleared.
- waitrequest_slave drops in the first clock edge after rst_i is released.
- A transfer is accepted on any cycle with (write_slave or read_slave) and waitrequest_slave = 0.
- IDLE_S (waitrequest_slave = 0):
  - On accepted write: beat 0 is written at address_slave; wr_cnt = max(burstcount,1) - 1; wr_addr = address_slave + 1.
  - If wr_cnt = 0, stay in IDLE_S; else go to WR_BURST_S.
  - On accepted read: rd_addr = address_slave; rd_cnt = max(burstcount,1); go to RD_BURST_S.
  - write_slave and read_slave both high: write wins, read is dropped, sticky collision flag is set. The flag is visible in simulation only.
- WR_BURST_S (waitrequest_slave = 0):
  - Each cycle with write_slave high writes writedata_slave at wr_addr, masked by byteenable_slave; wr_addr increments and wr_cnt decrements.
  - Cycles with write_slave low are idle beats; no timeout.
  - Return to IDLE_S after the last beat. address_slave and burstcount_slave are ignored in this state.
- RD_BURST_S (waitrequest_slave = 1):
  - Each cycle issues one RAM read at rd_addr into a RD_LATENCY-deep valid/data pipe; rd_addr increments and rd_cnt decrements.
  - Return to IDLE_S the cycle after the last issue; waitrequest_slave drops that cycle.
  - Pipe drains independently, so a new command may be accepted while earlier data is still returning. Ordering is preserved.
- Read latency:
  - Data from a read accepted at edge N appears on edge N+RD_LATENCY, then one beat per cycle, back to back.
  - RAM read is synchronous and counts as pipe stage 1.
- Address arithmetic:
  - Increments are modulo 2^MEM_DEPTH_W, so bursts wrap at the top of RAM.
  - Upper address bits are ignored (aliasing).
- Write/read ordering: a read issued in the cycle after the last write beat returns the new data (write-first RAM, no bypass needed).
- Reset mid-burst: the burst is abandoned, no further readdatavalid_slave, and partial write beats stay written.

Optional Feature:
- Macro: AMM_RESP_ERR_INJ_EN.
- Defined: adds inputs err_inj_en_i (1), err_addr_i (MEM_DEPTH_W) and err_mask_i (DATA_W).
  - While err_inj_en_i is high, every read of word err_addr_i returns RAM data XOR err_mask_i. RAM itself is unmodified.
  - The compare happens at issue time, so the flip is aligned with that beat's readdatavalid_slave.
  - Used to prove the checker detects errors.
- Undefined: the ports do not exist and read data is always clean.

Decomposition:
- Shared package mem_checker_pkg:
  - state enum resp_state_t {IDLE_S, WR_BURST_S, RD_BURST_S}.
  - Default width constants ADDR_W, DATA_W, BURST_W.
- Sub-module amm_resp_ram: single-port, write-first, byte-enabled synchronous RAM, DATA_W x 2^MEM_DEPTH_W. Keeps the RAM inferable; the FSM and pipe stay in the top.

Test Plan:
- Single write 0xDEADBEEF at addr 0x0010, byteenable 0xF, then single read 0x0010 -> readdatavalid_slave exactly RD_LATENCY=2 cycles after accept, data 0xDEADBEEF.
- Write burst of 4 at 0x0020 with write_slave gapped on beat 2 -> 0x20..0x23 hold beats 0..3; read burst 4 -> 4 consecutive valid beats in order, waitrequest_slave high for 4 cycles.
- Byteenable 0x5 writing 0xAABBCCDD over 0x11223344 -> readback 0x11BB33DD.
- Read burst 3 at 0x03FF (MEM_DEPTH_W=10) -> data from 0x3FF, 0x000, 0x001; address 0x0400 aliases 0x000.
- burstcount_slave=0 write/read -> behaves as single beat; simultaneous read+write in IDLE_S -> write done, no readdatavalid_slave.
- rst_i low mid read burst (after 2 of 8 beats issued) -> readdatavalid_slave 0 immediately and stays 0; with AMM_RESP_ERR_INJ_EN, err_addr_i=0x10 and err_mask_i=0x1 -> read 0x10 returns 0xDEADBEEE.
